nes_cpu_bus_master: RTL and testbench
=====================================

NES_CPU_BUS_MASTER -- requirements
Module: nes_cpu_bus_master

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 6, meaning clk cycles per M2 half-phase; legal values are 2..255.
REQ-002 SHALL have parameter CYCLE_CNT_W, default 32, meaning the width of cycle_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a bus command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning the command is accepted this clk.
REQ-007 SHALL have port cmd_rw, input, 1, where 1 is a read and 0 is a write.
REQ-008 SHALL have port cmd_addr, input, 16, the 6502 address.
REQ-009 SHALL have port cmd_wdata, input, 8, the write data.
REQ-010 SHALL have port rsp_valid, output, 1, a one-clk completion pulse.
REQ-011 SHALL have port rsp_data, output, 8, the read data (valid only with rsp_valid).
REQ-012 SHALL have port m2, output, 1, the CPU phase-2 clock to the cartridge.
REQ-013 SHALL have port romsel, output, 1, active-low, equal to ~(A15 & M2).
REQ-014 SHALL have port cpu_rw, output, 1, the bus R/W line.
REQ-015 SHALL have port cpu_addr, output, 15, the bus address A14..A0.
REQ-016 SHALL have port cpu_data_out, output, 8, the write data to the bus.
REQ-017 SHALL have port cpu_data_oe, output, 1, the bus data driver enable.
REQ-018 SHALL have port cpu_data_in, input, 8, the bus data sampled on reads.
REQ-019 SHALL have port irq, input, 1, the cartridge IRQ, active-low and asynchronous.
REQ-020 SHALL have port irq_pending, output, 1, the synchronised level ~irq.
REQ-021 SHALL have port cycle_count, output, CYCLE_CNT_W, the number of completed bus cycles.

Function
REQ-022 SHALL generate a continuous bus cycle of 2*HALF_PERIOD clks using a phase counter ph running 0..2*HALF_PERIOD-1 and then wrapping.
REQ-023 SHALL hold m2=0 for ph<HALF_PERIOD and m2=1 otherwise; m2 is a registered output.
REQ-024 SHALL accept commands only when ph==2*HALF_PERIOD-1, asserting cmd_ready in that clk only; accept means cmd_valid&cmd_ready.
REQ-025 SHALL use two FSM states: IDLE_CYC and CMD_CYC; the state is latched at ph wrap as CMD_CYC if a command was accepted, else IDLE_CYC.
REQ-026 SHALL, in IDLE_CYC, drive cpu_rw=1, cpu_data_oe=0 and hold the address of the last cycle (a dummy read); M2 keeps toggling so cartridge timers advance.
REQ-027 SHALL, in CMD_CYC, drive cpu_addr=cmd_addr[14:0] and cpu_rw=cmd_rw from ph==0; romsel falls with m2 rising when cmd_addr[15]=1, else romsel stays 1.
REQ-028 SHALL, for CMD_CYC writes, assert cpu_data_oe and drive cpu_data_out=cmd_wdata from ph==HALF_PERIOD/2 until the cycle end, then deassert at ph==0 of the next cycle.
REQ-029 SHALL, for CMD_CYC reads, sample cpu_data_in at ph==2*HALF_PERIOD-1 (last M2-high clk).
REQ-030 SHALL pulse rsp_valid for exactly one clk at ph==0 following a CMD_CYC, for both reads and writes; rsp_data holds the sample until the next read.
REQ-031 SHALL have a latency of 2*HALF_PERIOD+1 clks from accept to rsp_valid.
REQ-032 SHALL sustain back-to-back commands at one per bus cycle; an accept in the rsp_valid cycle is legal.
REQ-033 SHALL drive romsel glitch-free, registered from next-state m2 and A15.
REQ-034 SHALL increment cycle_count at every ph wrap, wrapping modulo 2^CYCLE_CNT_W.
REQ-035 SHALL pass irq through a 2-flop synchroniser, giving irq_pending=~irq_sync2.

Reset
REQ-036 SHALL, while rst=1, force ph=0, IDLE_CYC, m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_oe=0, cpu_data_out=0, cmd_ready=0, rsp_valid=0, rsp_data=0, cycle_count=0 and the IRQ synchroniser flops to 1.
REQ-037 SHALL, on reset mid-cycle, abort the command without rsp_valid and start a fresh cycle at ph=0 on the first clk after rst falls.

Structure
REQ-038 SHALL place the FSM state enum and ph width function in the shared package nes_bus_pkg.
REQ-039 SHALL be a single module; no sub-module except an optional nes_irq_sync 2-flop synchroniser.

Verification
REQ-040 SHALL cover reset, then 3 idle cycles with HALF_PERIOD=6: m2 period 12 clks, romsel=1, cpu_rw=1 and cycle_count=3.
REQ-041 SHALL cover a read of $8000 with the cartridge model returning $A5: romsel is low during m2 high only, and rsp_valid carries rsp_data=$A5 13 clks after accept.
REQ-042 SHALL cover a write of $5A to $6000: cpu_rw=0, oe is high from ph=3..11, romsel stays 1, and one rsp_valid pulse follows.
REQ-043 SHALL cover 4 back-to-back commands with cmd_valid held high: one accept per 12 clks, 4 rsp_valid pulses and no idle cycle between them.
REQ-044 SHALL cover rst asserted at ph=8 of a write: oe=0 and romsel=1 the next clk, no rsp_valid, and ph restarts at 0.
REQ-045 SHALL cover irq driven low asynchronously: irq_pending rises 2–3 clks later and clears 2–3 clks after irq returns high.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared bus-cycle FSM state type and phase-counter width helper
package nes_bus_pkg;

    typedef enum logic {
        IDLE_CYC = 1'b0,
        CMD_CYC  = 1'b1
    } cyc_state_e;

    // Bits needed for a phase counter spanning 0..2*half_period-1.
    function automatic int ph_width(input int half_period);
        return $clog2(2 * half_period);
    endfunction

endpackage

// File: rtl/nes_irq_sync.sv
// nes_irq_sync: two-flop synchroniser for the asynchronous active-low cartridge IRQ
//   clk      : clock
//   rst      : synchronous active-high reset, presets both flops to 1 (IRQ idle)
//   irq      : asynchronous input
//   irq_sync : synchronised copy of irq
module nes_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic irq_sync
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= irq;
            s2_q <= s1_q;
        end
    end

    assign irq_sync = s2_q;

endmodule

// File: rtl/nes_cpu_bus_master.sv
// nes_cpu_bus_master: NES 6502-style cartridge bus master, one command per M2 cycle
//   clk, rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake, ready only in the last phase of a bus cycle
//   cmd_rw/addr/wdata : command (1 = read), 16-bit address, write data
//   rsp_valid/data    : one-clk completion pulse, read data held until the next read
//   m2, romsel        : phase-2 clock and active-low PRG ROM select
//   cpu_rw/addr       : bus R/W and A14..A0
//   cpu_data_*        : bus write data, driver enable, read data
//   irq, irq_pending  : asynchronous active-low IRQ in, synchronised pending level out
//   cycle_count       : completed bus cycles, wrapping
module nes_cpu_bus_master
    import nes_bus_pkg::*;
#(
    parameter int HALF_PERIOD = 6,
    parameter int CYCLE_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [15:0]            cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   m2,
    output logic                   romsel,
    output logic                   cpu_rw,
    output logic [14:0]            cpu_addr,
    output logic [7:0]             cpu_data_out,
    output logic                   cpu_data_oe,
    input  logic [7:0]             cpu_data_in,
    input  logic                   irq,
    output logic                   irq_pending,
    output logic [CYCLE_CNT_W-1:0] cycle_count
);

    localparam int PH_W = ph_width(HALF_PERIOD);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(HALF_PERIOD);
    localparam logic [PH_W-1:0] PH_OE   = PH_W'(HALF_PERIOD / 2);

    cyc_state_e             state_q, state_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic                   m2_q, m2_d;
    logic                   romsel_q, romsel_d;
    logic                   a15_q, a15_d;
    logic                   rw_q, rw_d;
    logic [14:0]            addr_q, addr_d;
    logic [7:0]             dout_q, dout_d;
    logic                   oe_q, oe_d;
    logic                   ready_q, ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [7:0]             rsp_data_q, rsp_data_d;
    logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   wrap;
    logic                   accept;
    logic                   irq_sync;

    nes_irq_sync u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .irq_sync (irq_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE_CYC;
            ph_q        <= '0;
            m2_q        <= 1'b0;
            romsel_q    <= 1'b1;
            a15_q       <= 1'b0;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            m2_q        <= m2_d;
            romsel_q    <= romsel_d;
            a15_q       <= a15_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Every register is loaded from its next-state value, so outputs line up
    // with ph_q and romsel is a single flop with no decode glitches.
    always_comb begin
        wrap        = ph_q == PH_LAST;
        accept      = cmd_valid & ready_q;
        ph_d        = wrap ? '0 : ph_q + PH_W'(1);
        state_d     = wrap ? (accept ? CMD_CYC : IDLE_CYC) : state_q;
        rw_d        = wrap ? (accept ? cmd_rw : 1'b1) : rw_q;
        // Idle dummy reads keep the old address but never select PRG ROM.
        a15_d       = wrap ? accept & cmd_addr[15] : a15_q;
        addr_d      = accept ? cmd_addr[14:0] : addr_q;
        dout_d      = accept & ~cmd_rw ? cmd_wdata : dout_q;
        m2_d        = ph_d >= PH_HALF;
        romsel_d    = ~(a15_d & m2_d);
        oe_d        = state_d == CMD_CYC && !rw_d && ph_d >= PH_OE;
        ready_d     = ph_d == PH_LAST;
        rsp_valid_d = wrap && state_q == CMD_CYC;
        rsp_data_d  = wrap && state_q == CMD_CYC && rw_q ? cpu_data_in : rsp_data_q;
        cnt_d       = wrap ? cnt_q + CYCLE_CNT_W'(1) : cnt_q;
    end

    assign cmd_ready    = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign m2           = m2_q;
    assign romsel       = romsel_q;
    assign cpu_rw       = rw_q;
    assign cpu_addr     = addr_q;
    assign cpu_data_out = dout_q;
    assign cpu_data_oe  = oe_q;
    assign irq_pending  = ~irq_sync;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// tb_nes_cpu_bus_master: directed self-checking bench for nes_cpu_bus_master (HALF_PERIOD=6)
module tb_nes_cpu_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;
    logic        irq = 1'b1;
    logic        irq_pending;
    logic [31:0] cycle_count;
    logic [7:0]  rom_byte = 8'hA5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Cartridge model: PRG ROM answers only while selected.
    assign cpu_data_in = romsel ? 8'h00 : rom_byte;

    nes_cpu_bus_master #(.HALF_PERIOD(6), .CYCLE_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in),
        .irq          (irq),
        .irq_pending  (irq_pending),
        .cycle_count  (cycle_count)
    );

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ticks(3);
        checks++;
        if ({m2, romsel, cpu_rw, cpu_data_oe, cmd_ready, rsp_valid} !== 6'b011000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 011000", {m2, romsel, cpu_rw, cpu_data_oe, cmd_ready, rsp_valid});
        end
        checks++;
        if ({cpu_addr, cpu_data_out, rsp_data} !== 31'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h dout=%h rsp_data=%h expected zeros", cpu_addr, cpu_data_out, rsp_data);
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", cycle_count);
        end
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq_pending);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle;
        int ph;
        for (int i = 1; i <= 36; i++) begin
            ticks(1);
            ph = i % 12;
            checks++;
            if ({m2, romsel, cpu_rw, cpu_data_oe, cmd_ready, rsp_valid} !== {ph >= 6, 1'b1, 1'b1, 1'b0, ph == 11, 1'b0}) begin
                errors++;
                $display("FAIL idle_ph%0d: got %b expected %b", ph,
                         {m2, romsel, cpu_rw, cpu_data_oe, cmd_ready, rsp_valid},
                         {ph >= 6, 1'b1, 1'b1, 1'b0, ph == 11, 1'b0});
            end
        end
        checks++;
        if (cycle_count !== 32'd3) begin
            errors++;
            $display("FAIL idle_count: got %0d expected 3", cycle_count);
        end
    endtask

    task automatic test_read;
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = 16'h8000;
        rom_byte  = 8'hA5;
        ticks(11);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_ready: got %b expected 1", cmd_ready);
        end
        ticks(1);
        cmd_valid = 1'b0;
        checks++;
        if ({cpu_addr, cpu_rw, romsel, rsp_valid} !== {15'h0000, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_start: addr=%h rw=%b romsel=%b rsp=%b expected 0000 1 1 0", cpu_addr, cpu_rw, romsel, rsp_valid);
        end
        for (int p = 1; p < 12; p++) begin
            ticks(1);
            checks++;
            if ({m2, romsel, rsp_valid} !== {p >= 6, p < 6, 1'b0}) begin
                errors++;
                $display("FAIL read_ph%0d: m2/romsel/rsp got %b expected %b", p, {m2, romsel, rsp_valid}, {p >= 6, p < 6, 1'b0});
            end
        end
        ticks(1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_rsp: valid=%b data=%h expected 1 a5", rsp_valid, rsp_data);
        end
        ticks(1);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_rsp_pulse: valid=%b data=%h expected 0 a5", rsp_valid, rsp_data);
        end
        ticks(11);
    endtask

    task automatic test_write;
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 16'h6000;
        cmd_wdata = 8'h5A;
        ticks(11);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready: got %b expected 1", cmd_ready);
        end
        ticks(1);
        cmd_valid = 1'b0;
        cmd_rw    = 1'b1;
        for (int p = 0; p < 12; p++) begin
            if (p > 0) ticks(1);
            checks++;
            if ({cpu_rw, romsel, cpu_data_oe, rsp_valid, cpu_addr} !== {1'b0, 1'b1, p >= 3, 1'b0, 15'h6000}) begin
                errors++;
                $display("FAIL write_ph%0d: rw/romsel/oe/rsp/addr got %b %b %b %b %h expected 0 1 %b 0 6000",
                         p, cpu_rw, romsel, cpu_data_oe, rsp_valid, cpu_addr, p >= 3);
            end
            if (p >= 3) begin
                checks++;
                if (cpu_data_out !== 8'h5A) begin
                    errors++;
                    $display("FAIL write_data_ph%0d: got %h expected 5a", p, cpu_data_out);
                end
            end
        end
        ticks(1);
        checks++;
        if ({rsp_valid, cpu_data_oe, cpu_rw} !== 3'b101 || rsp_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_rsp: valid/oe/rw got %b data=%h expected 101 a5", {rsp_valid, cpu_data_oe, cpu_rw}, rsp_data);
        end
        ticks(1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp_pulse: got %b expected 0", rsp_valid);
        end
        ticks(11);
    endtask

    task automatic test_back_to_back;
        int nacc = 0;
        int nrsp = 0;
        int last_acc = 0;
        int last_rsp = 0;
        bit just_acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_addr  = 16'h8000;
        for (int t = 0; t < 80 && nrsp < 4; t++) begin
            ticks(1);
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== 8'h10 + 8'(nrsp)) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", nrsp, rsp_data, 8'h10 + 8'(nrsp));
                end
                if (nrsp > 0) begin
                    checks++;
                    if (t - last_rsp != 12) begin
                        errors++;
                        $display("FAIL b2b_rsp_gap%0d: got %0d expected 12", nrsp, t - last_rsp);
                    end
                end
                last_rsp = t;
                nrsp++;
            end
            if (just_acc) begin
                just_acc = 1'b0;
                checks++;
                if (cpu_addr !== 15'(nacc - 1)) begin
                    errors++;
                    $display("FAIL b2b_addr%0d: got %h expected %h", nacc - 1, cpu_addr, 15'(nacc - 1));
                end
                rom_byte = 8'h10 + 8'(nacc - 1);
                cmd_addr = 16'h8000 + 16'(nacc);
                if (nacc == 4) cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                if (nacc > 0) begin
                    checks++;
                    if (t - last_acc != 12) begin
                        errors++;
                        $display("FAIL b2b_acc_gap%0d: got %0d expected 12", nacc, t - last_acc);
                    end
                end
                last_acc = t;
                nacc++;
                just_acc = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (nacc != 4 || nrsp != 4) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d responses=%0d expected 4 4", nacc, nrsp);
        end
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 16'h6000;
        cmd_wdata = 8'h5A;
        ticks(12);
        cmd_valid = 1'b0;
        ticks(8);
        checks++;
        if (cpu_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_oe: got %b expected 1", cpu_data_oe);
        end
        rst = 1'b1;
        ticks(1);
        checks++;
        if ({cpu_data_oe, romsel, cpu_rw, rsp_valid, m2, cmd_ready} !== 6'b011000) begin
            errors++;
            $display("FAIL rstmid_forced: got %b expected 011000", {cpu_data_oe, romsel, cpu_rw, rsp_valid, m2, cmd_ready});
        end
        ticks(1);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            ticks(1);
            checks++;
            if ({rsp_valid, m2, cmd_ready, cpu_data_oe} !== {1'b0, (i % 12) >= 6, i == 11, 1'b0}) begin
                errors++;
                $display("FAIL rstmid_i%0d: rsp/m2/ready/oe got %b expected %b", i,
                         {rsp_valid, m2, cmd_ready, cpu_data_oe}, {1'b0, (i % 12) >= 6, i == 11, 1'b0});
            end
        end
        checks++;
        if (cycle_count !== 32'd1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d expected 1", cycle_count);
        end
    endtask

    task automatic test_irq;
        int n;
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_idle: got %b expected 0", irq_pending);
        end
        @(negedge clk);
        #2 irq = 1'b0;
        n = 0;
        while (irq_pending !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n < 2 || n > 3) begin
            errors++;
            $display("FAIL irq_assert_latency: got %0d clks expected 2..3", n);
        end
        @(negedge clk);
        #3 irq = 1'b1;
        n = 0;
        while (irq_pending !== 1'b0 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n < 2 || n > 3) begin
            errors++;
            $display("FAIL irq_release_latency: got %0d clks expected 2..3", n);
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_read;
        test_write;
        test_back_to_back;
        test_reset_mid;
        test_irq;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
